// File: rtl/instr_enc_pkg.sv
// instr_enc shared package: formats, opcodes, S1 bundle.
// Range helper exists only with INSTR_ENC_RANGE_CHECK_EN.
package instr_enc_pkg;

  localparam int DW = 64;
  localparam int IW = 32;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rng_err;
  } s1_t;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  function automatic logic sext_ok(
    input logic [DW-1:0] imm,
    input int            lsb
  );
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < DW; i++) begin
      if (i >= lsb) begin
        ones  = ones & imm[i];
        zeros = zeros & ~imm[i];
      end
    end
    return ones | zeros;
  endfunction

  function automatic logic imm_bad(
    input logic [2:0]    fmt,
    input logic [DW-1:0] imm
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      fmt == FMT_I,
      fmt == FMT_S: bad = !sext_ok(imm, 11);
      fmt == FMT_B: bad = !sext_ok(imm, 12) || imm[0];
      fmt == FMT_J: bad = !sext_ok(imm, 20) || imm[0];
      fmt == FMT_U: bad = !sext_ok(imm, 31) || (|imm[11:0]);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

endpackage

// File: rtl/instr_enc_if.sv
// instr_enc request/response handshake bundle.
// master drives requests, slave is the encoder.
interface instr_enc_if;
  import instr_enc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [DW-1:0] in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic          out_err;

  modport master (
    output in_valid, in_fmt, in_opcode,
    output in_rd, in_rs1, in_rs2,
    output in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode,
    input  in_rd, in_rs1, in_rs2,
    input  in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid,
    output out_instr, out_err
  );

endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational RV64I field packer.
// Illegal fmt yields a zero word with err set.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  input  logic          rng_err,
  output logic [IW-1:0] instr,
  output logic          err
);

  always_comb begin
    instr = '0;
    err   = rng_err;
    unique case (1'b1)
      fmt == FMT_R:
        instr = {funct7, rs2, rs1,
                 funct3, rd, opcode};
      fmt == FMT_I:
        instr = {imm[11:0], rs1,
                 funct3, rd, opcode};
      fmt == FMT_S:
        instr = {imm[11:5], rs2, rs1,
                 funct3, imm[4:0], opcode};
      fmt == FMT_B:
        instr = {imm[12], imm[10:5],
                 rs2, rs1, funct3,
                 imm[4:1], imm[11], opcode};
      fmt == FMT_U:
        instr = {imm[31:12], rd, opcode};
      fmt == FMT_J:
        instr = {imm[20], imm[10:1],
                 imm[11], imm[19:12],
                 rd, opcode};
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_enc.sv
// instr_enc: two-stage RV64I instruction encoder.
// INSTR_ENC_RANGE_CHECK_EN adds immediate range errors.
module instr_enc
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  instr_enc_if.slave  bus,
  output logic [15:0] enc_cnt
);

  s1_t           s1_d;
  s1_t           s1_q;
  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic [IW-1:0] pk_instr;
  logic          pk_err;

  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;

  always_comb begin
    s1_d        = '0;
    s1_d.fmt    = bus.in_fmt;
    s1_d.opcode = bus.in_opcode;
    s1_d.rd     = bus.in_rd;
    s1_d.rs1    = bus.in_rs1;
    s1_d.rs2    = bus.in_rs2;
    s1_d.funct3 = bus.in_funct3;
    s1_d.funct7 = bus.in_funct7;
    s1_d.imm    = bus.in_imm[31:0];
`ifdef INSTR_ENC_RANGE_CHECK_EN
    s1_d.rng_err = imm_bad(bus.in_fmt, bus.in_imm);
`else
    s1_d.rng_err = 1'b0;
`endif
  end

`ifndef INSTR_ENC_RANGE_CHECK_EN
  // upper immediate bits only matter to the range check
  logic unused_imm_hi;
  assign unused_imm_hi = ^bus.in_imm[DW-1:32];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid)
        s1_q <= s1_d;
    end
  end

  instr_pack u_pack (
    .fmt     (s1_q.fmt),
    .opcode  (s1_q.opcode),
    .rd      (s1_q.rd),
    .rs1     (s1_q.rs1),
    .rs2     (s1_q.rs2),
    .funct3  (s1_q.funct3),
    .funct7  (s1_q.funct7),
    .imm     (s1_q.imm),
    .rng_err (s1_q.rng_err),
    .instr   (pk_instr),
    .err     (pk_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      bus.out_instr <= '0;
      bus.out_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_instr <= pk_instr;
        bus.out_err   <= pk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      enc_cnt <= '0;
    else if (s2_valid && bus.out_ready)
      enc_cnt <= enc_cnt + 16'd1;
  end

endmodule
